// File: rtl/if_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl_if
//   Request/acknowledge bus between the IF fetch sequencer and a
//   variable-latency instruction memory.
//
//   Signals:
//     req    fetch request at the current PC (sequencer -> memory)
//     ack    read data valid this cycle    (memory -> sequencer)
//     rdata  instruction word, valid when ack=1 (memory -> sequencer)
//
//   Modports:
//     master  the fetch sequencer
//     slave   the instruction memory
// ----------------------------------------------------------------------------
interface if_fetch_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             ack;
  logic [WIDTH-1:0] rdata;

  modport master (output req, input ack, input rdata);
  modport slave  (input req, output ack, output rdata);
endinterface

// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl
//   Fetch sequencer for the IF stage. It drives the PC load enable and the
//   next-PC select, and handshakes with a variable-latency instruction memory.
//   A word that arrives while ID is frozen is parked in a hold register. On a
//   taken branch, any fetch still in flight is drained and discarded.
//
//   Ports:
//     clk            system clock, rising edge
//     rst            synchronous reset, active-high
//     imem           instruction memory bus (master side: req out; ack, rdata in)
//     i_freeze       ID stall request; IF/ID must not load
//     i_br_taken     branch resolved taken in EXE; redirect fetch
//     o_pc_write     PC register load enable
//     o_pc_sel       next-PC select: 0 = PC+4, 1 = branch target
//     o_if_valid     IF/ID load enable; the instruction is valid
//     o_if_flush     clear IF/ID to a bubble
//     o_instruction  word presented to IF/ID
//     o_timeout      sticky flag: MAX_WAIT cycles passed without an ack
// ----------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_ctrl_if.master   imem,
  input  logic              i_freeze,
  input  logic              i_br_taken,
  output logic              o_pc_write,
  output logic              o_pc_sel,
  output logic              o_if_valid,
  output logic              o_if_flush,
  output logic [WIDTH-1:0]  o_instruction,
  output logic              o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_hold;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               r_timeout;
  logic               w_load_hold;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_WAIT);

  // Next state and Mealy outputs. The priority is: branch, then ack, then
  // freeze. While rst is high, every output is forced to 0, even though the
  // state register has not yet returned to IDLE.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. Without it,
    // any path that skips an assignment infers a latch.
    w_next        = r_state;
    w_load_hold   = 1'b0;
    imem.req      = 1'b0;
    o_pc_write    = 1'b0;
    o_pc_sel      = 1'b0;
    o_if_valid    = 1'b0;
    o_if_flush    = 1'b0;
    o_instruction = '0;

    if (!rst) begin
      unique case (r_state)
        S_IDLE: w_next = S_FETCH;

        S_FETCH: begin
          imem.req      = 1'b1;
          o_instruction = imem.rdata;
          if (i_br_taken) begin
            o_pc_write = 1'b1;
            o_pc_sel   = 1'b1;
            o_if_flush = 1'b1;
            // If the ack arrives with the branch, it completes the old fetch
            // now and nothing is left outstanding. Otherwise, the pending
            // response still has to be drained.
            w_next     = imem.ack ? S_FETCH : S_DRAIN;
          end else if (imem.ack && !i_freeze) begin
            o_if_valid = 1'b1;
            o_pc_write = 1'b1;
          end else if (imem.ack) begin
            w_load_hold = 1'b1;
            w_next      = S_HOLD;
          end
        end

        S_HOLD: begin
          o_instruction = r_hold;
          if (i_br_taken) begin
            o_pc_write = 1'b1;
            o_pc_sel   = 1'b1;
            o_if_flush = 1'b1;
            w_next     = S_FETCH;
          end else if (!i_freeze) begin
            o_if_valid = 1'b1;
            o_pc_write = 1'b1;
            w_next     = S_FETCH;
          end
        end

        S_DRAIN: begin
          // The data shown here belongs to the discarded fetch. It never
          // reaches IF/ID because if_valid stays low.
          o_instruction = imem.rdata;
          if (i_br_taken) begin
            o_pc_write = 1'b1;
            o_pc_sel   = 1'b1;
            o_if_flush = 1'b1;
          end
          if (imem.ack) w_next = S_FETCH;
        end

        default: w_next = S_IDLE;
      endcase
    end
  end

  // The wait counter clears on an ack and on any state change. It counts only
  // cycles in which a response is outstanding and absent, and it saturates at
  // MAX_WAIT.
  always_comb begin
    w_cnt_next = r_wait_cnt;
    if (imem.ack || (w_next != r_state)) begin
      w_cnt_next = '0;
    end else if ((r_state == S_FETCH || r_state == S_DRAIN) && (r_wait_cnt != CntMax)) begin
      w_cnt_next = r_wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // that every register samples pre-edge values.
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
      // NOTE: the hold register is reset as well. This makes the word shown in
      // HOLD deterministic even though it is only read after a load.
      r_hold     <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_cnt_next;
      if (w_load_hold)         r_hold    <= imem.rdata;
      if (w_cnt_next == CntMax) r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout & ~rst;

endmodule
